// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host-side transmit and receive blocks:
// FSM state encoding, default timing constants, frame geometry and the
// odd-parity helper.
package ps2_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_INHIBIT = 4'd1,
    ST_REQ     = 4'd2,
    ST_START   = 4'd3,
    ST_DATA    = 4'd4,
    ST_PARITY  = 4'd5,
    ST_STOP    = 4'd6,
    ST_RELEASE = 4'd7,
    ST_DONE    = 4'd8,
    ST_ERROR   = 4'd9
  } ps2_state_e;

  // Default timing at a 10 MHz system clock.
  localparam int DEF_INHIBIT_CYCLES       = 1200;    // >= 100 us clock inhibit
  localparam int DEF_REQ_CYCLES           = 8;       // both lines low before clock release
  localparam int DEF_START_TIMEOUT_CYCLES = 150000;  // 15 ms for the device to start clocking
  localparam int DEF_XFER_TIMEOUT_CYCLES  = 20000;   // 2 ms from first edge to line release

  // Frame: start, 8 data bits, parity, stop (the ACK rides on the 11th clock).
  localparam int FRAME_BITS = 11;
  localparam int DATA_BITS  = FRAME_BITS - 3;

  // Consecutive cycles the synced clock must hold before the filter follows it.
  localparam int GLITCH_STABLE_CYCLES = 4;

  // PS/2 parity bit: makes the total count of ones across data+parity odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// One PS/2 line: 2-FF synchronizer, optional glitch filter and falling-edge
// detector. The filter is enabled per instance through FILTER_EN; lines idle
// high, so every stage resets to 1 to avoid a false edge after reset.
module ps2_line_sync
  import ps2_pkg::*;
#(
  parameter bit FILTER_EN = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic line_i,
  output logic level_o,
  output logic fe_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;
  logic cur;

  // Two-stage synchronizer for the asynchronous pad input.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= line_i;
      sync_q <= meta_q;
    end
  end

  generate
    if (FILTER_EN) begin : g_filter
      localparam int CW = $clog2(GLITCH_STABLE_CYCLES);
      logic [CW-1:0] cnt_q;
      logic          filt_q;

      // Follow the synced value only once it has held long enough; any
      // return to the filtered value restarts the count.
      always_ff @(posedge clk) begin
        if (!rst) begin
          cnt_q  <= '0;
          filt_q <= 1'b1;
        end else if (sync_q == filt_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CW'(GLITCH_STABLE_CYCLES - 2)) begin
          filt_q <= sync_q;
          cnt_q  <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end

      assign cur = filt_q;
    end else begin : g_direct
      assign cur = sync_q;
    end
  endgenerate

  // Previous value for edge detection.
  always_ff @(posedge clk) begin
    if (!rst) prev_q <= 1'b1;
    else      prev_q <= cur;
  end

  assign level_o = cur;
  assign fe_o    = prev_q & ~cur;

endmodule

// File: rtl/ps2_data_output.sv
// Host-to-device PS/2 transmitter. Performs the clock inhibit and
// request-to-send, shifts out the 11-bit frame on device clock falling
// edges, checks the device ACK and waits for both lines to be released.
// Line drives are pull-low enables for external open-drain pads.
// Optional: define PS2_TX_GLITCH_FILTER_EN to glitch-filter ps2_clk before
// edge detection (adds 3 cycles of edge latency).
module ps2_data_output
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES       = DEF_INHIBIT_CYCLES,
  parameter int REQ_CYCLES           = DEF_REQ_CYCLES,
  parameter int START_TIMEOUT_CYCLES = DEF_START_TIMEOUT_CYCLES,
  parameter int XFER_TIMEOUT_CYCLES  = DEF_XFER_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       ps2_clk_drive_low,
  output logic       ps2_data_drive_low,
  output logic       tx_done_strb,
  output logic       tx_error_strb
);

  // One counter width covers every timed phase.
  localparam int TMAX = max2(max2(INHIBIT_CYCLES, REQ_CYCLES),
                             max2(START_TIMEOUT_CYCLES, XFER_TIMEOUT_CYCLES));
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] INH_LAST   = TW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] REQ_LAST   = TW'(REQ_CYCLES - 1);
  localparam logic [TW-1:0] START_LAST = TW'(START_TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] XFER_LAST  = TW'(XFER_TIMEOUT_CYCLES - 1);

`ifdef PS2_TX_GLITCH_FILTER_EN
  localparam bit CLK_FILTER_EN = 1'b1;
`else
  localparam bit CLK_FILTER_EN = 1'b0;
`endif

  ps2_state_e    state_q;
  logic          clk_drv_q;
  logic          data_drv_q;
  logic          done_q;
  logic          err_q;
  logic [TW-1:0] cnt_q;
  logic [TW-1:0] xfer_q;
  logic [3:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          parity_q;

  logic clk_level;
  logic clk_fe;
  logic data_level;
  logic data_fe_unused;
  logic xfer_run;
  logic abort;

  ps2_line_sync #(.FILTER_EN(CLK_FILTER_EN)) u_clk_sync (
    .clk    (clk),
    .rst    (rst),
    .line_i (ps2_clk),
    .level_o(clk_level),
    .fe_o   (clk_fe)
  );

  ps2_line_sync #(.FILTER_EN(1'b0)) u_data_sync (
    .clk    (clk),
    .rst    (rst),
    .line_i (ps2_data),
    .level_o(data_level),
    .fe_o   (data_fe_unused)
  );

  // Timeouts take priority over any edge seen in the same cycle.
  assign xfer_run = (state_q == ST_DATA)   || (state_q == ST_PARITY) ||
                    (state_q == ST_STOP)   || (state_q == ST_RELEASE);
  assign abort    = ((state_q == ST_START) && (cnt_q == START_LAST)) ||
                    (xfer_run && (xfer_q == XFER_LAST));

  // Transmit FSM with registered line drives and strobes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      clk_drv_q  <= 1'b0;
      data_drv_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      xfer_q     <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;

      if (abort) begin
        state_q    <= ST_ERROR;
        err_q      <= 1'b1;
        clk_drv_q  <= 1'b0;
        data_drv_q <= 1'b0;
      end else begin
        // The transfer timer saturates rather than wrapping.
        if (xfer_run && (xfer_q != '1)) xfer_q <= xfer_q + 1'b1;

        case (state_q)
          ST_IDLE: begin
            clk_drv_q  <= 1'b0;
            data_drv_q <= 1'b0;
            if (tx_valid) begin
              shift_q   <= tx_data;
              parity_q  <= odd_parity(tx_data);
              cnt_q     <= '0;
              clk_drv_q <= 1'b1;
              state_q   <= ST_INHIBIT;
            end
          end

          ST_INHIBIT: begin
            if (cnt_q == INH_LAST) begin
              cnt_q      <= '0;
              data_drv_q <= 1'b1;
              state_q    <= ST_REQ;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end

          ST_REQ: begin
            if (cnt_q == REQ_LAST) begin
              cnt_q     <= '0;
              clk_drv_q <= 1'b0;
              state_q   <= ST_START;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end

          // Data held low is the start bit; the device now generates clocks.
          ST_START: begin
            cnt_q <= cnt_q + 1'b1;
            if (clk_fe) begin
              data_drv_q <= ~shift_q[0];
              bit_cnt_q  <= 4'd1;
              xfer_q     <= '0;
              state_q    <= ST_DATA;
            end
          end

          ST_DATA: begin
            if (clk_fe) begin
              if (bit_cnt_q == 4'(DATA_BITS)) begin
                data_drv_q <= ~parity_q;
                state_q    <= ST_PARITY;
              end else begin
                data_drv_q <= ~shift_q[bit_cnt_q[2:0]];
                bit_cnt_q  <= bit_cnt_q + 4'd1;
              end
            end
          end

          // Releasing data presents the stop bit.
          ST_PARITY: begin
            if (clk_fe) begin
              data_drv_q <= 1'b0;
              state_q    <= ST_STOP;
            end
          end

          // Device pulls data low around the 11th clock to acknowledge.
          ST_STOP: begin
            if (clk_fe) begin
              if (!data_level) begin
                state_q <= ST_RELEASE;
              end else begin
                state_q <= ST_ERROR;
                err_q   <= 1'b1;
              end
            end
          end

          ST_RELEASE: begin
            if (clk_level && data_level) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end

          ST_DONE:  state_q <= ST_IDLE;
          ST_ERROR: state_q <= ST_IDLE;

          default: begin
            state_q    <= ST_IDLE;
            clk_drv_q  <= 1'b0;
            data_drv_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign tx_ready           = (state_q == ST_IDLE);
  assign ps2_clk_drive_low  = clk_drv_q;
  assign ps2_data_drive_low = data_drv_q;
  assign tx_done_strb       = done_q;
  assign tx_error_strb      = err_q;

endmodule

// File: tb/tb_ps2_data_output.sv
// Directed bench for ps2_data_output: an open-drain bus with a PS/2 device
// model that clocks frames, samples bits on its rising clock edges and
// optionally ACKs. The start timeout is shortened to keep the run short.
module tb_ps2_data_output;

  localparam int INH      = 1200;
  localparam int REQ      = 8;
  localparam int START_TO = 3000;
  localparam int XFER_TO  = 20000;
  localparam int H        = 100;  // device clock half period in system cycles

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       ps2_clk_drive_low;
  logic       ps2_data_drive_low;
  logic       tx_done_strb;
  logic       tx_error_strb;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2_clk;
  logic       ps2_data;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int frames = 0;
  logic clk_drv_prev = 1'b0;

  always #5 clk = ~clk;

  // Open-drain wired-AND of host and device pull-downs.
  assign ps2_clk  = ~(ps2_clk_drive_low  | dev_clk_low);
  assign ps2_data = ~(ps2_data_drive_low | dev_data_low);

  ps2_data_output #(
    .INHIBIT_CYCLES      (INH),
    .REQ_CYCLES          (REQ),
    .START_TIMEOUT_CYCLES(START_TO),
    .XFER_TIMEOUT_CYCLES (XFER_TO)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .ps2_clk           (ps2_clk),
    .ps2_data          (ps2_data),
    .tx_data           (tx_data),
    .tx_valid          (tx_valid),
    .tx_ready          (tx_ready),
    .ps2_clk_drive_low (ps2_clk_drive_low),
    .ps2_data_drive_low(ps2_data_drive_low),
    .tx_done_strb      (tx_done_strb),
    .tx_error_strb     (tx_error_strb)
  );

  // Strobe and frame-start counters.
  always @(negedge clk) begin
    if (tx_done_strb)  done_cnt++;
    if (tx_error_strb) err_cnt++;
    if (ps2_clk_drive_low && !clk_drv_prev) frames++;
    clk_drv_prev = ps2_clk_drive_low;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Device side of one frame. Waits for the host to release the clock with
  // data low, then issues npulses clocks, sampling data before each rising
  // edge. With ack set it pulls data low between the 10th and 11th rise.
  task automatic dev_frame(input int npulses, input bit ack,
                           output logic [7:0] b, output logic par,
                           output logic stp, output bit found);
    b = 8'h00; par = 1'bx; stp = 1'bx; found = 1'b0;
    for (int i = 0; i < 5000 && !found; i++) begin
      @(negedge clk);
      if (!ps2_clk_drive_low && ps2_data_drive_low) found = 1'b1;
    end
    if (!found) return;
    wait_cycles(H);
    check("start_bit_held", {31'd0, ps2_data_drive_low}, 32'd1);
    for (int p = 1; p <= npulses; p++) begin
      dev_clk_low = 1'b1;
      wait_cycles(H);
      if (p <= 8)       b[p-1] = ps2_data;
      else if (p == 9)  par = ps2_data;
      else if (p == 10) stp = ps2_data;
      dev_clk_low = 1'b0;
      if (p == 10 && ack) dev_data_low = 1'b1;
      if (p == 11)        dev_data_low = 1'b0;
      if (p != npulses) wait_cycles(H);
    end
  endtask

  // Bounded wait for either strobe; leaves time for counters to settle.
  task automatic wait_strobe(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (tx_done_strb || tx_error_strb) seen = 1'b1;
    end
    wait_cycles(4);
  endtask

  task automatic do_frame(input string tag, input logic [7:0] d, input bit ack,
                          input logic exp_par, input bit exp_done);
    int d0, e0;
    logic [7:0] b;
    logic par, stp;
    bit found, seen;
    d0 = done_cnt; e0 = err_cnt;
    tx_data = d; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    dev_frame(11, ack, b, par, stp, found);
    check({tag, "_found"}, {31'd0, found}, 32'd1);
    wait_strobe(seen);
    check({tag, "_byte"},   {24'd0, b}, {24'd0, d});
    check({tag, "_parity"}, {31'd0, par}, {31'd0, exp_par});
    check({tag, "_stop"},   {31'd0, stp}, 32'd1);
    check({tag, "_done"},   done_cnt - d0, exp_done ? 32'd1 : 32'd0);
    check({tag, "_error"},  err_cnt - e0,  exp_done ? 32'd0 : 32'd1);
    check({tag, "_ready"},  {31'd0, tx_ready}, 32'd1);
  endtask

  initial begin
    int d0, e0, f0, clk_hi, data_rise, n;
    logic [7:0] b;
    logic par, stp;
    bit found, seen;

    // Reset state.
    wait_cycles(3);
    check("rst_ready",    {31'd0, tx_ready}, 32'd1);
    check("rst_clk_drv",  {31'd0, ps2_clk_drive_low}, 32'd0);
    check("rst_data_drv", {31'd0, ps2_data_drive_low}, 32'd0);
    check("rst_done",     {31'd0, tx_done_strb}, 32'd0);
    check("rst_err",      {31'd0, tx_error_strb}, 32'd0);
    rst = 1'b1;
    wait_cycles(5);

    // 0xED with request timing: clock held 1208 cycles, data joins at 1200.
    d0 = done_cnt; e0 = err_cnt;
    tx_data = 8'hED; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    clk_hi = 0; data_rise = -1;
    for (int k = 0; k < 3000; k++) begin
      if (!ps2_clk_drive_low) break;
      clk_hi++;
      if (ps2_data_drive_low && data_rise < 0) data_rise = k;
      @(negedge clk);
    end
    check("req_clk_cycles",   clk_hi, INH + REQ);
    check("req_data_rise",    data_rise, INH);
    check("req_data_at_rel",  {31'd0, ps2_data_drive_low}, 32'd1);
    dev_frame(11, 1'b1, b, par, stp, found);
    check("ed_found", {31'd0, found}, 32'd1);
    wait_strobe(seen);
    check("ed_byte",   {24'd0, b}, 32'hED);
    check("ed_parity", {31'd0, par}, 32'd1);
    check("ed_stop",   {31'd0, stp}, 32'd1);
    check("ed_done",   done_cnt - d0, 32'd1);
    check("ed_error",  err_cnt - e0, 32'd0);
    check("ed_ready",  {31'd0, tx_ready}, 32'd1);

    // Parity corner bytes.
    do_frame("p00", 8'h00, 1'b1, 1'b1, 1'b1);
    do_frame("p01", 8'h01, 1'b1, 1'b0, 1'b1);
    do_frame("pff", 8'hFF, 1'b1, 1'b1, 1'b1);

    // No device clocking: start timeout counted from START entry.
    d0 = done_cnt; e0 = err_cnt;
    tx_data = 8'h55; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge clk);
      if (!ps2_clk_drive_low && ps2_data_drive_low) found = 1'b1;
    end
    check("to_start_seen", {31'd0, found}, 32'd1);
    n = 0;
    while (!tx_error_strb && n < START_TO + 100) begin
      @(negedge clk);
      n++;
    end
    check("to_cycles",   n, START_TO);
    check("to_clk_drv",  {31'd0, ps2_clk_drive_low}, 32'd0);
    check("to_data_drv", {31'd0, ps2_data_drive_low}, 32'd0);
    @(negedge clk);
    check("to_ready", {31'd0, tx_ready}, 32'd1);
    wait_cycles(3);
    check("to_error", err_cnt - e0, 32'd1);
    check("to_done",  done_cnt - d0, 32'd0);

    // Device never ACKs: error, no done.
    do_frame("nack", 8'hAA, 1'b0, 1'b1, 1'b0);

    // tx_valid held through the whole transfer: one frame only.
    d0 = done_cnt; f0 = frames;
    tx_data = 8'h12; tx_valid = 1'b1;
    dev_frame(11, 1'b1, b, par, stp, found);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (tx_done_strb) seen = 1'b1;
    end
    tx_valid = 1'b0;
    check("hold_done_seen", {31'd0, seen}, 32'd1);
    check("hold_byte",   {24'd0, b}, 32'h12);
    check("hold_parity", {31'd0, par}, 32'd1);
    wait_cycles(50);
    check("hold_frames",  frames - f0, 32'd1);
    check("hold_done",    done_cnt - d0, 32'd1);
    check("hold_clk_drv", {31'd0, ps2_clk_drive_low}, 32'd0);

    // Reset after four data bits, then a clean 0xF4.
    d0 = done_cnt; e0 = err_cnt;
    tx_data = 8'h3C; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    dev_frame(4, 1'b1, b, par, stp, found);
    check("mid_found", {31'd0, found}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("mid_clk_drv",  {31'd0, ps2_clk_drive_low}, 32'd0);
    check("mid_data_drv", {31'd0, ps2_data_drive_low}, 32'd0);
    check("mid_ready",    {31'd0, tx_ready}, 32'd1);
    rst = 1'b1;
    wait_cycles(10);
    check("mid_no_done", done_cnt - d0, 32'd0);
    check("mid_no_err",  err_cnt - e0, 32'd0);
    do_frame("f4", 8'hF4, 1'b1, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
